// File: rtl/uart_mmio_responder_pkg.sv
// Shared definitions for the memory-mapped UART responder: default window base,
// register word indices, STATUS/CTRL bit positions, the RX "no data" code and
// the RX poll FSM state encoding.
package uart_mmio_responder_pkg;

  // Default base of the 32-byte device window (32-byte aligned).
  localparam logic [63:0] UartBase = 64'h0000_0000_1000_0000;

  // Register selection uses addr[4:3]; addr[2:0] is ignored.
  localparam logic [1:0] RegData   = 2'd0;  // offset 0x00
  localparam logic [1:0] RegStatus = 2'd1;  // offset 0x08
  localparam logic [1:0] RegCtrl   = 2'd2;  // offset 0x10
  localparam logic [1:0] RegRsvd   = 2'd3;  // offset 0x18

  // STATUS bit positions.
  localparam int unsigned StatusTxFull   = 0;
  localparam int unsigned StatusTxEmpty  = 1;
  localparam int unsigned StatusRxValid  = 2;
  localparam int unsigned StatusTxDrop   = 3;
  localparam int unsigned StatusCountLsb = 8;

  // CTRL bit positions.
  localparam int unsigned CtrlTxEn = 0;
  localparam int unsigned CtrlRxEn = 1;

  // Character returned by the host side when no input is pending.
  localparam logic [7:0] RxNoData = 8'hFF;

  typedef enum logic [1:0] {
    RxIdle,
    RxPoll,
    RxFull
  } rx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmit path.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset (empties the FIFO)
//   push_i  - write data_i; accepted when not full, or when full and a pop
//             happens in the same cycle
//   data_i  - byte to write
//   pop_i   - remove the head entry (ignored when empty)
//   data_o  - head entry
//   full_o  - count == Depth
//   empty_o - count == 0
//   count_o - number of stored entries (0..Depth)
module uart_tx_fifo #(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [7:0]       mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap naturally.
      if (push_ok) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_mmio_responder.sv
// Memory-mapped UART responder on the core's data port.
// Serves three 64-bit registers in a 32-byte window at BASE_ADDR:
//   0x00 DATA   - store pushes a TX byte, load returns/pops the RX byte
//   0x08 STATUS - {tx_count, tx_drop, rx_valid, tx_empty, tx_full}
//   0x10 CTRL   - {rx_en, tx_en}
//   0x18        - reserved
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   data_en, wen          - load / store request this cycle
//   addr, wdata, wmask    - byte address, lane-shifted store data and bit mask
//   rdata, sel            - combinational load data and window hit
//   io_uart_out_valid/ch  - registered TX byte strobe and byte
//   io_uart_in_valid      - registered RX poll strobe
//   io_uart_in_ch         - RX byte sampled during the poll strobe (8'hFF = none)
module uart_mmio_responder
  import uart_mmio_responder_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = UartBase,
  parameter int unsigned TX_DEPTH  = 16,
  parameter int unsigned TX_DIV    = 1,
  parameter int unsigned RX_POLL   = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_en,
  input  logic        wen,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [63:0] wmask,
  output logic [63:0] rdata,
  output logic        sel,
  output logic        io_uart_out_valid,
  output logic [7:0]  io_uart_out_ch,
  output logic        io_uart_in_valid,
  input  logic [7:0]  io_uart_in_ch
);

  localparam int unsigned CntW     = $clog2(TX_DEPTH) + 1;
  localparam logic [31:0] DivLast  = 32'(TX_DIV - 1);
  localparam logic [31:0] PollLast = 32'(RX_POLL - 1);

  // Decode
  logic [1:0] reg_idx;
  logic       byte_wr, data_st, data_ld, status_ld, ctrl_st;

  assign sel       = (addr[63:5] == BASE_ADDR[63:5]);
  assign reg_idx   = addr[4:3];
  assign byte_wr   = |wmask[7:0];
  assign data_st   = sel & wen & byte_wr & (reg_idx == RegData);
  assign ctrl_st   = sel & wen & byte_wr & (reg_idx == RegCtrl);
  assign data_ld   = sel & data_en & (reg_idx == RegData);
  assign status_ld = sel & data_en & (reg_idx == RegStatus);

  logic unused_bits;
  assign unused_bits = ^{addr[2:0], wdata[63:8], wmask[63:8]};

  // TX FIFO
  logic            tx_full, tx_empty, tx_fire;
  logic [7:0]      tx_head;
  logic [CntW-1:0] tx_count;
  logic [8:0]      tx_count_ext;
  logic [7:0]      tx_count_sat;

  uart_tx_fifo #(
    .Depth (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (data_st),
    .data_i  (wdata[7:0]),
    .pop_i   (tx_fire),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  // Only a 256-deep FIFO can exceed the 8-bit STATUS field.
  assign tx_count_ext = 9'(tx_count);
  assign tx_count_sat = (tx_count_ext > 9'd255) ? 8'hFF : tx_count_ext[7:0];

  // Control/status registers and TX divider
  logic        tx_en_q, tx_en_d, rx_en_q, rx_en_d;
  logic        tx_drop_q, tx_drop_d;
  logic [31:0] div_q, div_d;
  logic        out_valid_q;
  logic [7:0]  out_ch_q;

  always_comb begin
    tx_en_d   = tx_en_q;
    rx_en_d   = rx_en_q;
    tx_drop_d = tx_drop_q;
    if (ctrl_st) begin
      tx_en_d = wdata[CtrlTxEn];
      rx_en_d = wdata[CtrlRxEn];
    end
    if (status_ld) tx_drop_d = 1'b0;
    if (data_st && tx_full && !tx_fire) tx_drop_d = 1'b1;
  end

  // Divider runs only while enabled with data queued; tx_en=0 freezes it.
  always_comb begin
    div_d   = div_q;
    tx_fire = 1'b0;
    if (tx_empty) begin
      div_d = '0;
    end else if (tx_en_q) begin
      if (div_q == DivLast) begin
        tx_fire = 1'b1;
        div_d   = '0;
      end else begin
        div_d = div_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_en_q     <= 1'b1;
      rx_en_q     <= 1'b1;
      tx_drop_q   <= 1'b0;
      div_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      tx_en_q     <= tx_en_d;
      rx_en_q     <= rx_en_d;
      tx_drop_q   <= tx_drop_d;
      div_q       <= div_d;
      out_valid_q <= tx_fire;
      if (tx_fire) out_ch_q <= tx_head;
    end
  end

  assign io_uart_out_valid = out_valid_q;
  assign io_uart_out_ch    = out_ch_q;

  // RX poll FSM
  rx_state_e   rx_state_q;
  logic [31:0] poll_q;
  logic [7:0]  rx_byte_q;
  logic        in_valid_q;
  logic        rx_valid;

  assign rx_valid = (rx_state_q == RxFull);

  // The strobe is raised on entry to RxPoll so it is high for exactly the
  // cycle in which io_uart_in_ch is sampled.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q <= RxIdle;
      poll_q     <= '0;
      rx_byte_q  <= '0;
      in_valid_q <= 1'b0;
    end else begin
      in_valid_q <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (!rx_en_q) begin
            poll_q <= '0;
          end else if (poll_q == PollLast) begin
            poll_q     <= '0;
            rx_state_q <= RxPoll;
            in_valid_q <= 1'b1;
          end else begin
            poll_q <= poll_q + 32'd1;
          end
        end
        RxPoll: begin
          poll_q <= '0;
          if (io_uart_in_ch != RxNoData) begin
            rx_byte_q  <= io_uart_in_ch;
            rx_state_q <= RxFull;
          end else begin
            rx_state_q <= RxIdle;
          end
        end
        RxFull: begin
          if (data_ld) begin
            poll_q     <= '0;
            rx_state_q <= RxIdle;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  assign io_uart_in_valid = in_valid_q;

  // Load data: reflects state before any same-cycle store or pop commits.
  always_comb begin
    rdata = '0;
    if (sel && data_en) begin
      unique case (reg_idx)
        RegData: rdata = {55'b0, rx_valid, rx_byte_q};
        RegStatus: begin
          rdata[StatusTxFull]            = tx_full;
          rdata[StatusTxEmpty]           = tx_empty;
          rdata[StatusRxValid]           = rx_valid;
          rdata[StatusTxDrop]            = tx_drop_q;
          rdata[StatusCountLsb +: 8]     = tx_count_sat;
        end
        RegCtrl: rdata = {62'b0, rx_en_q, tx_en_q};
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_responder.sv
module tb_uart_mmio_responder;

  localparam logic [63:0] Base    = 64'h0000_0000_1000_0000;
  localparam logic [63:0] AData   = Base;
  localparam logic [63:0] AStatus = Base + 64'h08;
  localparam logic [63:0] ACtrl   = Base + 64'h10;
  localparam logic [63:0] ByteMsk = 64'hFF;

  logic        clock = 1'b0;
  logic        reset, data_en, wen;
  logic [63:0] addr, wdata, wmask, rdata;
  logic        sel, out_valid, in_valid;
  logic [7:0]  out_ch, in_ch;

  uart_mmio_responder #(
    .BASE_ADDR (Base),
    .TX_DEPTH  (4),
    .TX_DIV    (1),
    .RX_POLL   (4)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .data_en           (data_en),
    .wen               (wen),
    .addr              (addr),
    .wdata             (wdata),
    .wmask             (wmask),
    .rdata             (rdata),
    .sel               (sel),
    .io_uart_out_valid (out_valid),
    .io_uart_out_ch    (out_ch),
    .io_uart_in_valid  (in_valid),
    .io_uart_in_ch     (in_ch)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {logic [63:0] data; logic sel;} rd_exp_t;
  typedef struct {logic [7:0] ch; int at;} tx_exp_t;

  rd_exp_t rd_q[$];
  tx_exp_t tx_q[$];
  int      poll_q[$];
  bit      check_polls = 1'b0;
  int      n_cmp = 0;
  int      n_bad = 0;

  // Monitor: compares every presented output against the scoreboard queues.
  always @(negedge clock) begin
    rd_exp_t re;
    tx_exp_t te;
    int      pe;
    if (data_en) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL load_unexpected addr=%h got rdata=%h", addr, rdata);
      end else begin
        re = rd_q.pop_front();
        if (rdata !== re.data || sel !== re.sel) begin
          n_bad++;
          $display("FAIL load addr=%h got rdata=%h sel=%b want rdata=%h sel=%b",
                   addr, rdata, sel, re.data, re.sel);
        end
      end
    end else begin
      n_cmp++;
      if (rdata !== 64'h0) begin
        n_bad++;
        $display("FAIL rdata_idle got %h want 0", rdata);
      end
    end
    if (out_valid) begin
      n_cmp++;
      if (tx_q.size() == 0) begin
        n_bad++;
        $display("FAIL tx_unexpected cyc=%0d got ch=%h want no byte", cyc, out_ch);
      end else begin
        te = tx_q.pop_front();
        if (out_ch !== te.ch || (te.at >= 0 && te.at != cyc)) begin
          n_bad++;
          $display("FAIL tx_byte got ch=%h cyc=%0d want ch=%h cyc=%0d",
                   out_ch, cyc, te.ch, te.at);
        end
      end
    end
    if (in_valid && check_polls) begin
      n_cmp++;
      if (poll_q.size() == 0) begin
        n_bad++;
        $display("FAIL rx_poll_unexpected got poll at cyc=%0d want none", cyc);
      end else begin
        pe = poll_q.pop_front();
        if (pe != cyc) begin
          n_bad++;
          $display("FAIL rx_poll_time got cyc=%0d want cyc=%0d", cyc, pe);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [63:0] a, input logic [63:0] d, input logic s);
    rd_q.push_back('{data: d, sel: s});
    addr = a;
    data_en = 1'b1;
    tick();
    data_en = 1'b0;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [63:0] m);
    addr = a;
    wdata = d;
    wmask = m;
    wen = 1'b1;
    tick();
    wen = 1'b0;
  endtask

  task automatic load_store(input logic [63:0] a, input logic [63:0] d, input logic [63:0] exp);
    rd_q.push_back('{data: exp, sel: 1'b1});
    addr = a;
    wdata = d;
    wmask = ByteMsk;
    wen = 1'b1;
    data_en = 1'b1;
    tick();
    wen = 1'b0;
    data_en = 1'b0;
  endtask

  task automatic leftover(input string name, input int n);
    n_cmp++;
    if (n != 0) begin
      n_bad++;
      $display("FAIL %s_pending got %0d outstanding want 0", name, n);
    end
  endtask

  initial begin
    int k;
    reset = 1'b1;
    data_en = 1'b0;
    wen = 1'b0;
    addr = '0;
    wdata = '0;
    wmask = '0;
    in_ch = 8'hFF;
    tick(3);
    reset = 1'b0;

    // Reset state
    load(AStatus, 64'h2, 1'b1);
    load(ACtrl, 64'h3, 1'b1);
    load(AData, 64'h0, 1'b1);

    // Two back-to-back bytes
    k = cyc;
    tx_q.push_back('{ch: 8'h48, at: k + 2});
    tx_q.push_back('{ch: 8'h69, at: k + 3});
    store(AData, 64'h48, ByteMsk);
    store(AData, 64'h69, ByteMsk);
    tick(4);
    load(AStatus, 64'h2, 1'b1);

    // Overflow with TX disabled, sticky drop, then ordered drain
    store(ACtrl, 64'h2, ByteMsk);
    for (int i = 0; i < 5; i++) store(AData, 64'(8'h10 + i), ByteMsk);
    load(AStatus, 64'h409, 1'b1);
    load(AStatus, 64'h401, 1'b1);
    k = cyc;
    for (int i = 0; i < 4; i++) tx_q.push_back('{ch: 8'(8'h10 + i), at: k + 2 + i});
    store(ACtrl, 64'h3, ByteMsk);
    tick(6);
    load(AStatus, 64'h2, 1'b1);

    // Push into a full FIFO in the cycle its head drains
    store(ACtrl, 64'h2, ByteMsk);
    for (int i = 0; i < 4; i++) store(AData, 64'(8'h20 + i), ByteMsk);
    k = cyc;
    for (int i = 0; i < 5; i++) tx_q.push_back('{ch: 8'(8'h20 + i), at: k + 2 + i});
    store(ACtrl, 64'h3, ByteMsk);
    store(AData, 64'h24, ByteMsk);
    load(AStatus, 64'h401, 1'b1);
    tick(6);
    load(AStatus, 64'h2, 1'b1);

    // RX polling: restart the poll counter by toggling rx_en
    store(ACtrl, 64'h1, ByteMsk);
    tick(3);
    k = cyc;
    for (int i = 1; i <= 4; i++) poll_q.push_back(k + 5 * i);
    check_polls = 1'b1;
    store(ACtrl, 64'h3, ByteMsk);
    tick(15);
    in_ch = 8'h41;
    tick(6);
    in_ch = 8'hFF;
    tick(10);
    load(AStatus, 64'h6, 1'b1);
    k = cyc;
    poll_q.push_back(k + 5);
    poll_q.push_back(k + 10);
    load(AData, 64'h141, 1'b1);
    load(AData, 64'h41, 1'b1);
    tick(10);
    check_polls = 1'b0;
    leftover("rx_poll", poll_q.size());

    // Reset while bytes are queued: only the byte already leaving appears
    store(ACtrl, 64'h2, ByteMsk);
    for (int i = 0; i < 3; i++) store(AData, 64'(8'h30 + i), ByteMsk);
    k = cyc;
    tx_q.push_back('{ch: 8'h30, at: k + 2});
    store(ACtrl, 64'h3, ByteMsk);
    tick(1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(5);
    load(AStatus, 64'h2, 1'b1);
    load(ACtrl, 64'h3, 1'b1);

    // Window edges, reserved slot and ignored stores
    load(Base + 64'h1F, 64'h0, 1'b1);
    load(Base + 64'h0F, 64'h2, 1'b1);
    load(Base + 64'h20, 64'h0, 1'b0);
    load(Base - 64'h08, 64'h0, 1'b0);
    store(Base + 64'h18, 64'h55, ByteMsk);
    store(Base + 64'h20, 64'h77, ByteMsk);
    store(Base + 64'h30, 64'h0, ByteMsk);
    store(AData, 64'h99, 64'hFF00);
    store(ACtrl, 64'h0, 64'hFF00);
    tick(4);
    load(AStatus, 64'h2, 1'b1);
    load(ACtrl, 64'h3, 1'b1);

    // Same-cycle load and store to CTRL returns the old value
    load_store(ACtrl, 64'h1, 64'h3);
    load(ACtrl, 64'h1, 1'b1);
    store(ACtrl, 64'h3, ByteMsk);
    tick(5);

    leftover("tx", tx_q.size());
    leftover("load", rd_q.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
